// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain. Each stage carries a valid bit, can be
// stalled or flushed individually, and the oldest stage drives a ready/valid
// output handshake. The accept chain ripples combinationally from the output
// back to the input, so bubbles are overwritten without costing a cycle.
module pipe_stage_chain #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4,
  parameter int unsigned CW     = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_en,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall_req,
  input  logic [STAGES-1:0]       flush_req,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic [CW-1:0]           occupancy
);

  logic [STAGES-1:0] validQ, validD;
  logic [WIDTH-1:0]  dataQ    [STAGES];
  logic [WIDTH-1:0]  dataD    [STAGES];
  logic [WIDTH-1:0]  prevData [STAGES];
  logic [STAGES-1:0] pass, accept, leave, killMask, prevValid;

  // Handshake chain: a stage accepts when it is not stalled and is either a
  // bubble or its occupant leaves this cycle; evaluated oldest to youngest.
  always_comb begin
    pass   = validQ & ~stall_req;
    leave  = '0;
    accept = '0;
    leave[STAGES-1]  = out_ready & ~flush_req[STAGES-1];
    accept[STAGES-1] = cpu_en & ~stall_req[STAGES-1] & (~validQ[STAGES-1] | leave[STAGES-1]);
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      leave[i]  = accept[i+1];
      accept[i] = cpu_en & ~stall_req[i] & (~validQ[i] | leave[i]);
    end
  end

  // killMask[i] is set when stage i is at or below the highest flushed stage;
  // prevValid/prevData describe what each stage would load on accept.
  always_comb begin
    killMask    = '0;
    prevValid   = '0;
    prevValid[0] = in_valid;
    prevData[0]  = in_data;
    for (int i = 0; i < int'(STAGES); i++) begin
      killMask[i] = |(flush_req >> i);
    end
    for (int i = 1; i < int'(STAGES); i++) begin
      // A killed predecessor hands over a bubble, never its payload.
      prevValid[i] = pass[i-1] & ~killMask[i-1];
      prevData[i]  = dataQ[i-1];
    end
  end

  // Next-state: load on accept, otherwise hold; flush clears valid last so it
  // overrides both stall and hold.
  always_comb begin
    validD = validQ;
    for (int i = 0; i < int'(STAGES); i++) begin
      dataD[i] = dataQ[i];
    end
    if (cpu_en) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (accept[i]) begin
          validD[i] = prevValid[i];
          dataD[i]  = prevData[i];
        end
        if (killMask[i]) begin
          validD[i] = 1'b0;
        end
      end
    end
  end

  // Stage registers with asynchronous clear of both valid and payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        dataQ[i] <= '0;
      end
    end else begin
      validQ <= validD;
      for (int i = 0; i < int'(STAGES); i++) begin
        dataQ[i] <= dataD[i];
      end
    end
  end

  // Output handshake, flattened stage view and occupancy popcount.
  always_comb begin
    // Held low during reset regardless of cpu_en.
    in_ready    = accept[0] & ~rst;
    out_valid   = cpu_en & pass[STAGES-1] & ~flush_req[STAGES-1];
    out_data    = dataQ[STAGES-1];
    stage_valid = validQ;
    stage_data  = '0;
    occupancy   = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      stage_data[i*WIDTH +: WIDTH] = dataQ[i];
      occupancy = occupancy + CW'(validQ[i]);
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (STAGES=4, WIDTH=8): a directed
// vector table, hand-written corner sequences and a randomized run, all also
// compared every cycle against a slot-level reference model.
module tb_pipe_stage_chain;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAGES = 4;
  localparam int unsigned CW     = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cpu_en;
  logic                    in_valid;
  logic [WIDTH-1:0]        in_data;
  logic                    in_ready;
  logic [STAGES-1:0]       stall_req;
  logic [STAGES-1:0]       flush_req;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ready;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic [CW-1:0]           occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_chain #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_en     (cpu_en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .stall_req  (stall_req),
    .flush_req  (flush_req),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .stage_valid(stage_valid),
    .stage_data (stage_data),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: one slot per stage, each either empty or holding an item.
  bit             mValid [STAGES];
  logic [WIDTH-1:0] mData [STAGES];
  bit             nValid [STAGES];
  logic [WIDTH-1:0] nData [STAGES];
  bit             eInReady, eOutValid;
  logic [WIDTH-1:0] got [$];

  typedef struct {
    bit               inValid;
    logic [WIDTH-1:0] inData;
    logic [3:0]       expSv;
    bit               expInReady;
    bit               expOutValid;
    logic [WIDTH-1:0] expOutData;
    int               expOcc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < int'(STAGES); i++) begin
      mValid[i] = 1'b0;
      mData[i]  = '0;
    end
  endtask

  // Work out, from the oldest slot down, which slots can take a new occupant;
  // then move items one slot older and apply the flush kill region.
  task automatic modelComb();
    int f;
    bit room;
    bit enter [STAGES];
    f = -1;
    for (int i = 0; i < int'(STAGES); i++) if (flush_req[i]) f = i;
    for (int i = 0; i < int'(STAGES); i++) begin
      nValid[i] = mValid[i];
      nData[i]  = mData[i];
      enter[i]  = 1'b0;
    end
    eInReady  = 1'b0;
    eOutValid = 1'b0;
    if (!rst && cpu_en) begin
      room = out_ready && !flush_req[STAGES-1];
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
        enter[i] = !stall_req[i] && (!mValid[i] || room);
        room     = enter[i];
      end
      eInReady  = enter[0];
      eOutValid = mValid[STAGES-1] && !stall_req[STAGES-1] && !flush_req[STAGES-1];
      for (int i = 0; i < int'(STAGES); i++) begin
        if (i <= f) begin
          nValid[i] = 1'b0;
        end else if (enter[i]) begin
          if (i == 0) begin
            nValid[i] = in_valid;
            nData[i]  = in_data;
          end else begin
            nValid[i] = mValid[i-1] && !stall_req[i-1] && (i - 1 > f);
            nData[i]  = mData[i-1];
          end
        end
      end
    end
  endtask

  task automatic modelCheck();
    logic [3:0] ev;
    int cnt;
    cnt = 0;
    for (int i = 0; i < int'(STAGES); i++) begin
      ev[i] = mValid[i];
      cnt += int'(mValid[i]);
    end
    chk("model_in_ready", 32'(in_ready), 32'(eInReady));
    chk("model_out_valid", 32'(out_valid), 32'(eOutValid));
    if (eOutValid) chk("model_out_data", 32'(out_data), 32'(mData[STAGES-1]));
    chk("model_stage_valid", 32'(stage_valid), 32'(ev));
    chk("model_occupancy", 32'(occupancy), 32'(cnt));
    for (int i = 0; i < int'(STAGES); i++) begin
      if (mValid[i]) chk("model_stage_data", 32'(stage_data[i*WIDTH +: WIDTH]), 32'(mData[i]));
    end
  endtask

  // Let combinational outputs settle, compare with the model, log transfers.
  task automatic settle();
    #1;
    modelComb();
    modelCheck();
    if (out_valid && out_ready) got.push_back(out_data);
  endtask

  task automatic clockIt();
    @(posedge clk);
    modelComb();
    if (!rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        mValid[i] = nValid[i];
        mData[i]  = nData[i];
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    clockIt();
  endtask

  task automatic idle();
    cpu_en    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    stall_req = '0;
    flush_req = '0;
    out_ready = 1'b1;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    clearModel();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves D in stage 3, C in 2, B in 1, A in 0.
  task automatic fillAbcd();
    logic [WIDTH-1:0] seq [4];
    seq[0] = 8'h0D; seq[1] = 8'h0C; seq[2] = 8'h0B; seq[3] = 8'h0A;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = seq[i];
      cycle();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic chkGot(input string name, input int n, input logic [31:0] e0,
                        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({name, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) chk({name, "_order"}, 32'(got[i]), e[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    logic [WIDTH-1:0] nextA;

    vecs[0] = '{1'b1, 8'h11, 4'b0000, 1'b1, 1'b0, 8'h00, 0};
    vecs[1] = '{1'b1, 8'h22, 4'b0001, 1'b1, 1'b0, 8'h00, 1};
    vecs[2] = '{1'b1, 8'h33, 4'b0011, 1'b1, 1'b0, 8'h00, 2};
    vecs[3] = '{1'b0, 8'h00, 4'b0111, 1'b1, 1'b0, 8'h00, 3};
    vecs[4] = '{1'b0, 8'h00, 4'b1110, 1'b1, 1'b1, 8'h11, 3};
    vecs[5] = '{1'b0, 8'h00, 4'b1100, 1'b1, 1'b1, 8'h22, 2};
    vecs[6] = '{1'b0, 8'h00, 4'b1000, 1'b1, 1'b1, 8'h33, 1};
    vecs[7] = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 0};

    // Reset state, with cpu_en and in_valid high.
    idle();
    in_valid = 1'b1;
    rst = 1'b1;
    clearModel();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stage_valid", 32'(stage_valid), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    chk("reset_occupancy", 32'(occupancy), 32'h0);
    rst = 1'b0;
    idle();
    @(negedge clk);

    // Directed vector table: three pushes through an empty pipe.
    for (int r = 0; r < 8; r++) begin
      in_valid = vecs[r].inValid;
      in_data  = vecs[r].inData;
      settle();
      chk("vec_stage_valid", 32'(stage_valid), 32'(vecs[r].expSv));
      chk("vec_in_ready", 32'(in_ready), 32'(vecs[r].expInReady));
      chk("vec_out_valid", 32'(out_valid), 32'(vecs[r].expOutValid));
      if (vecs[r].expOutValid) chk("vec_out_data", 32'(out_data), 32'(vecs[r].expOutData));
      chk("vec_occupancy", 32'(occupancy), 32'(vecs[r].expOcc));
      clockIt();
    end

    // Backpressure: exactly STAGES accepted, then a gap-free drain/resume.
    doReset();
    out_ready = 1'b0;
    nextA = 8'hA0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = nextA;
      settle();
      if (in_ready) begin
        accepted++;
        nextA++;
      end
      clockIt();
    end
    chk("bp_accepted", 32'(accepted), 32'd4);
    in_data = nextA;
    settle();
    chk("bp_full_in_ready", 32'(in_ready), 32'h0);
    chk("bp_full_occupancy", 32'(occupancy), 32'd4);
    clockIt();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = nextA;
      settle();
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out_data", 32'(out_data), 32'(8'hA0 + k));
      chk("bp_in_ready", 32'(in_ready), 32'h1);
      if (in_ready) nextA++;
      clockIt();
    end
    idle();

    // Stall of stage 1 while the older half drains.
    doReset();
    fillAbcd();
    out_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 7; k++) begin
      stall_req = (k < 2) ? 4'b0010 : 4'b0000;
      settle();
      if (k < 2) chk("stall_in_ready", 32'(in_ready), 32'h0);
      if (k == 1) chk("stall_stage_valid", 32'(stage_valid), 32'b1011);
      if (k == 2) chk("stall_after_valid", 32'(stage_valid), 32'b0011);
      clockIt();
    end
    chkGot("stall_drain", 4, 32'h0D, 32'h0C, 32'h0B, 32'h0A);
    idle();

    // Flush of stages 0..1 with an offered input that must be dropped.
    doReset();
    fillAbcd();
    out_ready = 1'b0;
    flush_req = 4'b0010;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    cycle();
    idle();
    out_ready = 1'b0;
    settle();
    chk("flush_stage_valid", 32'(stage_valid), 32'b1100);
    chk("flush_occupancy", 32'(occupancy), 32'd2);
    clockIt();
    out_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 5; k++) cycle();
    chkGot("flush_drain", 2, 32'h0D, 32'h0C, 32'h0, 32'h0);

    // Asynchronous reset mid-stream, then a fresh push with normal latency.
    doReset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(k);
      cycle();
    end
    #1 rst = 1'b1;
    clearModel();
    #1;
    chk("midrst_stage_valid", 32'(stage_valid), 32'h0);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_occupancy", 32'(occupancy), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    #1 rst = 1'b0;
    in_data = 8'h5A;
    cycle();
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      settle();
      chk("latency_out_valid", 32'(out_valid), (j == 3) ? 32'h1 : 32'h0);
      if (j == 3) chk("latency_out_data", 32'(out_data), 32'h5A);
      clockIt();
    end

    // cpu_en=0 freezes everything, including flush and the handshakes.
    doReset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h61;
    cycle();
    in_data   = 8'h62;
    cycle();
    in_valid  = 1'b0;
    cycle();
    cpu_en    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b1;
    flush_req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("frz_in_ready", 32'(in_ready), 32'h0);
      chk("frz_out_valid", 32'(out_valid), 32'h0);
      chk("frz_stage_valid", 32'(stage_valid), 32'b0110);
      chk("frz_s2_data", 32'(stage_data[23:16]), 32'h61);
      chk("frz_s1_data", 32'(stage_data[15:8]), 32'h62);
      clockIt();
    end
    idle();
    got.delete();
    for (int k = 0; k < 4; k++) cycle();
    chkGot("frz_resume", 2, 32'h61, 32'h62, 32'h0, 32'h0);

    // Randomized traffic against the reference model.
    doReset();
    for (int k = 0; k < 1500; k++) begin
      cpu_en    = ($urandom_range(9) != 0);
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(9) < 7);
      for (int i = 0; i < int'(STAGES); i++) stall_req[i] = ($urandom_range(7) == 0);
      flush_req = ($urandom_range(15) == 0) ? 4'(1 << $urandom_range(3)) : 4'b0000;
      cycle();
    end
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
